// File: rtl/ms_bcd_counter.sv
// Millisecond stopwatch core: prescaler to a 1 ms tick feeding a cascaded BCD digit chain.
// Optional build macro MS_BCD_COUNTER_SATURATE_EN makes the count saturate at all 9s instead of wrapping.
module ms_bcd_counter #(
    parameter int DIV  = 100000,
    parameter int NDIG = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              STOP,
    input  logic              CLR,
    output logic              TICK,
    output logic [4*NDIG-1:0] DIGITS,
    output logic              RUNNING,
    output logic              OVF
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
`ifdef MS_BCD_COUNTER_SATURATE_EN
    localparam logic [1:0] SAT  = 2'd3;
`endif

    localparam logic [19:0] PRESC_LAST = 20'(DIV - 1);

    logic [1:0]        state, state_d;
    logic [19:0]       presc, presc_d;
    logic [4*NDIG-1:0] digits_d;
    logic              ovf_d, tick_d;

    function automatic logic [4*NDIG-1:0] bcd_inc(input logic [4*NDIG-1:0] v);
        logic [4*NDIG-1:0] r;
        logic              carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic bcd_all_nine(input logic [4*NDIG-1:0] v);
        logic r;
        r = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] != 4'd9) r = 1'b0;
        end
        return r;
    endfunction

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state;
        presc_d  = presc;
        digits_d = DIGITS;
        ovf_d    = OVF;
        tick_d   = 1'b0;
        if (CLR) begin
            state_d  = IDLE;
            presc_d  = '0;
            digits_d = '0;
            ovf_d    = 1'b0;
        end else begin
            case (state)
                IDLE: if (!STOP && START) state_d = RUN;
                RUN: begin
                    // A pause beats a coinciding terminal prescale: the partial millisecond is kept.
                    if (STOP) begin
                        state_d = HOLD;
                    end else if (presc == PRESC_LAST) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        if (bcd_all_nine(DIGITS)) begin
                            ovf_d = 1'b1;
`ifdef MS_BCD_COUNTER_SATURATE_EN
                            state_d = SAT;
`else
                            digits_d = '0;
`endif
                        end else begin
                            digits_d = bcd_inc(DIGITS);
                        end
                    end else begin
                        presc_d = presc + 20'd1;
                    end
                end
                HOLD: if (!STOP && START) state_d = RUN;
`ifdef MS_BCD_COUNTER_SATURATE_EN
                SAT: state_d = SAT;
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            presc   <= '0;
            DIGITS  <= '0;
            TICK    <= 1'b0;
            RUNNING <= 1'b0;
            OVF     <= 1'b0;
        end else begin
            state   <= state_d;
            presc   <= presc_d;
            DIGITS  <= digits_d;
            TICK    <= tick_d;
            RUNNING <= (state_d == RUN);
            OVF     <= ovf_d;
        end
    end

endmodule

// File: doc/ms_bcd_counter.md
Name: ms_bcd_counter

Overview:
- Millisecond stopwatch core. Divides CLK down to a 1 ms tick and counts elapsed milliseconds in cascaded BCD digits.
- Controlled by START/STOP/CLR pulses.
- It is the count-producing side of the terminal-count comparison scheme:
  - the prescaler generates the count;
  - the block detects its own terminal count;
  - the digit chain consumes the resulting tick.
- Feeds the display multiplexer and downstream threshold comparators.

Parameters:
- DIV, 100000, CLK cycles per 1 ms tick (100 MHz clock). Legal range 2..2^20.
- NDIG, 4, number of BCD digits (max count 10^NDIG - 1). Legal range 1..8.

Ports:
- CLK      input   1         system clock, rising edge
- RST      input   1         reset; asynchronous, active-high
- START    input   1         start/resume request, sampled each cycle
- STOP     input   1         pause request, sampled each cycle
- CLR      input   1         synchronous clear request
- TICK     output  1         one-cycle pulse per counted millisecond
- DIGITS   output  4*NDIG    BCD count; digit 0 (units) in bits [3:0]
- RUNNING  output  1         high while in RUN
- OVF      output  1         sticky overflow/terminal flag

Behaviour:
- Reset (RST high, async):
  - state=IDLE, prescaler=0, DIGITS=0, TICK=0, RUNNING=0, OVF=0.
- States:
  - IDLE: cleared, not counting.
  - RUN: counting.
  - HOLD: paused, count retained.
  - SAT: only exists with the optional feature.
- Request priority in the same cycle: CLR > STOP > START.
- CLR, any state:
  - next edge → IDLE, prescaler=0, DIGITS=0, OVF=0, TICK=0.
- Transitions:
  - IDLE + START → RUN.
  - RUN + STOP → HOLD.
  - HOLD + START → RUN.
  - START in RUN, STOP in IDLE/HOLD: ignored.
- Prescaler:
  - 20-bit, counts only in RUN.
  - On an RUN edge with prescaler==DIV-1: prescaler←0, TICK←1, BCD chain increments on that same edge.
  - Otherwise TICK←0.
  - First TICK appears exactly DIV cycles after the edge that entered RUN.
- STOP/HOLD:
  - Prescaler value is frozen, not cleared; resume continues the partial millisecond.
  - STOP on the same edge as prescaler==DIV-1: STOP wins, no tick, no increment.
- BCD increment:
  - Digit i increments when all lower digits are 9.
  - A digit at 9 that increments wraps to 0.
  - Digits never hold values above 9.
- Terminal count (all digits 9) plus tick, default build:
  - DIGITS wrap to all zero, OVF←1 (sticky until CLR or RST), stay in RUN, TICK pulses normally.
- RUNNING = (state==RUN), registered.
- All outputs registered; no combinational path from inputs to outputs.
- RST mid-operation overrides everything immediately.

Optional Feature:
- Macro: MS_BCD_COUNTER_SATURATE_EN.
- Defined:
  - At terminal count plus tick, DIGITS stay at all 9s and OVF←1.
  - State → SAT: RUNNING=0, prescaler stops, no further TICK.
  - START and STOP are ignored in SAT; only CLR or RST exits, to IDLE.
- Undefined: wrap behaviour as described under Behaviour; SAT state is not present.

Test Plan (DIV=4, NDIG=2 unless noted):
- RST mid-count with DIGITS=0x37 → all outputs 0 asynchronously. After release, outputs stay 0 until START.
- START pulse at cycle 0 → RUNNING=1 at cycle 1. TICK high at cycles 4, 8, 12. DIGITS=0x01, 0x02, 0x03 after those edges.
- Pause/resume with partial millisecond:
  - run to prescaler=2 with DIGITS=0x05, then STOP → HOLD;
  - wait 10 cycles → DIGITS unchanged, no TICK;
  - START → next TICK exactly 2 cycles after re-entering RUN, DIGITS=0x06.
- Carry and wrap: run from 0x09 → 0x10 with correct carry. From 0x99 plus tick → 0x00 with OVF=1 and RUNNING=1; OVF persists across a further 20 ticks.
- Same-cycle requests:
  - CLR+STOP+START in RUN → IDLE, DIGITS=0, OVF=0;
  - STOP coincident with prescaler==3 → no tick, no increment.
- With MS_BCD_COUNTER_SATURATE_EN, from 0x99 plus tick:
  - DIGITS=0x99, OVF=1, RUNNING=0, no TICK for 50 cycles;
  - START ignored;
  - CLR → IDLE with DIGITS=0x00.
